rr_arbiter: RTL and testbench

Round-robin arbiter sharing one downstream resource among `N` requesters. It reuses the MSB-first one-hot priority selection of the basic priority encoder, but rotates the starting point after every grant, so no requester can starve. It holds a registered grant until the owner releases it. Sits between requesting agents and a shared datapath, for example a bus port or a memory bank.

---
 rtl/rr_arbiter.sv | 105 ++++++++++
 tb/tb_rr_arbiter.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a registered, held one-hot grant and a rotating priority pointer.
// Optional forced release after TIMEOUT hold cycles when RR_ARBITER_TIMEOUT_EN is defined.
`timescale 1ns/1ps

module rr_arbiter #(
    parameter int N       = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 nreset,
    input  logic [N-1:0]         req,
    input  logic                 done,
    output logic [N-1:0]         grant,
    output logic                 grant_valid,
    output logic [$clog2(N)-1:0] grant_id,
    output logic                 timeout
);

    localparam int IW = $clog2(N);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    if (N < 2 || TIMEOUT < 2) begin : g_bad_cfg
        $error("rr_arbiter: N and TIMEOUT must both be at least 2");
    end

    logic [0:0]   state;
    logic [IW-1:0] ptr;
    logic [N-1:0] owner_mask;
    logic [N-1:0] arb_req;
    logic         found;
    logic [IW-1:0] win;
    logic         natural_rel;
    logic         force_rel;
    logic         release_now;

    // grant_id doubles as the owner index while BUSY
    assign owner_mask  = {{(N-1){1'b0}}, 1'b1} << grant_id;
    assign arb_req     = (state == BUSY) ? (req & ~owner_mask) : req;
    assign natural_rel = done || !req[grant_id];
    assign release_now = (state == BUSY) && (natural_rel || force_rel);
    assign grant_valid = (state == BUSY);

    // Search ptr, ptr-1, ..., 0, N-1, ..., ptr+1; first set request wins
    always_comb begin
        int idx;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) - i + N) % N;
            if (!found && arb_req[idx]) begin
                found = 1'b1;
                win   = IW'(idx);
            end
        end
    end

`ifdef RR_ARBITER_TIMEOUT_EN
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] hold_cnt;

    assign force_rel = (state == BUSY) && !natural_rel && (hold_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!nreset) begin
            hold_cnt <= '0;
        end else if (state == IDLE || release_now) begin
            hold_cnt <= '0;
        end else begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end
`else
    assign force_rel = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state    <= IDLE;
            ptr      <= IW'(N - 1);
            grant    <= '0;
            grant_id <= '0;
            timeout  <= 1'b0;
        end else begin
            timeout <= 1'b0;
            if (state == IDLE || release_now) begin
                timeout <= force_rel;
                if (found) begin
                    state    <= BUSY;
                    grant    <= {{(N-1){1'b0}}, 1'b1} << win;
                    grant_id <= win;
                    ptr      <= (win == '0) ? IW'(N - 1) : win - 1'b1;
                end else begin
                    state    <= IDLE;
                    grant    <= '0;
                    grant_id <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed self-checking bench for rr_arbiter (N=8, TIMEOUT=4).
// Covers reset, rotation, owner masking, withdrawal, mid-transaction reset and the hold timeout.
`timescale 1ns/1ps

module tb_rr_arbiter;

    logic       clk = 1'b0;
    logic       nreset;
    logic [7:0] req;
    logic       done;
    logic [7:0] grant;
    logic       grant_valid;
    logic [2:0] grant_id;
    logic       timeout;

    int n_asserts = 0;
    int n_fail    = 0;

    rr_arbiter #(.N(8), .TIMEOUT(4)) dut (
        .clk         (clk),
        .nreset      (nreset),
        .req         (req),
        .done        (done),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic rn, input logic [7:0] r, input logic d);
        nreset = rn;
        req    = r;
        done   = d;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] eg, input logic [2:0] eid,
                               input logic ev, input logic et);
        n_asserts++;
        assert (grant === eg) else begin
            n_fail++;
            $error("[TB] FAIL %s grant: observed %h expected %h", tag, grant, eg);
        end
        n_asserts++;
        assert (grant_id === eid) else begin
            n_fail++;
            $error("[TB] FAIL %s grant_id: observed %0d expected %0d", tag, grant_id, eid);
        end
        n_asserts++;
        assert (grant_valid === ev) else begin
            n_fail++;
            $error("[TB] FAIL %s grant_valid: observed %b expected %b", tag, grant_valid, ev);
        end
        n_asserts++;
        assert (timeout === et) else begin
            n_fail++;
            $error("[TB] FAIL %s timeout: observed %b expected %b", tag, timeout, et);
        end
    endtask

    initial begin
        logic [2:0] eid;

        // Reset state
        applyStimulus(1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("reset", 8'h00, 3'd0, 1'b0, 1'b0);

        // done while idle is ignored
        applyStimulus(1'b1, 8'h00, 1'b1);
        checkOutput("idle_done", 8'h00, 3'd0, 1'b0, 1'b0);

        // Single request
        applyStimulus(1'b1, 8'h10, 1'b0);
        checkOutput("single_grant", 8'h10, 3'd4, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'h00, 1'b1);
        checkOutput("single_release", 8'h00, 3'd0, 1'b0, 1'b0);

        // Rotation with all requesting and done every cycle
        applyStimulus(1'b0, 8'h00, 1'b0);
        applyStimulus(1'b1, 8'hFF, 1'b0);
        checkOutput("rot_first", 8'h80, 3'd7, 1'b1, 1'b0);
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b1, 8'hFF, 1'b1);
            eid = 3'(6 - k);
            checkOutput($sformatf("rot_%0d", k), 8'h01 << eid, eid, 1'b1, 1'b0);
        end

        // Owner masking on release
        applyStimulus(1'b0, 8'h00, 1'b0);
        applyStimulus(1'b1, 8'h81, 1'b0);
        checkOutput("mask_first", 8'h80, 3'd7, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'h81, 1'b1);
        checkOutput("mask_to_0", 8'h01, 3'd0, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'h81, 1'b1);
        checkOutput("mask_to_7", 8'h80, 3'd7, 1'b1, 1'b0);

        // Held grant ignores other request changes, then withdrawal
        applyStimulus(1'b0, 8'h00, 1'b0);
        applyStimulus(1'b1, 8'h08, 1'b0);
        checkOutput("wd_grant3", 8'h08, 3'd3, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'h28, 1'b0);
        checkOutput("wd_hold3", 8'h08, 3'd3, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'h20, 1'b0);
        checkOutput("wd_to_5", 8'h20, 3'd5, 1'b1, 1'b0);

        // Mid-transaction reset
        applyStimulus(1'b0, 8'h20, 1'b0);
        checkOutput("midreset", 8'h00, 3'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h03, 1'b0);
        checkOutput("post_reset", 8'h02, 3'd1, 1'b1, 1'b0);

        // Hold timeout behaviour
        applyStimulus(1'b0, 8'h00, 1'b0);
        applyStimulus(1'b1, 8'h06, 1'b0);
        checkOutput("to_grant2", 8'h04, 3'd2, 1'b1, 1'b0);
`ifdef RR_ARBITER_TIMEOUT_EN
        for (int k = 1; k < 4; k++) begin
            applyStimulus(1'b1, 8'h06, 1'b0);
            checkOutput($sformatf("to_hold_%0d", k), 8'h04, 3'd2, 1'b1, 1'b0);
        end
        applyStimulus(1'b1, 8'h06, 1'b0);
        checkOutput("to_fire", 8'h02, 3'd1, 1'b1, 1'b1);
        applyStimulus(1'b1, 8'h06, 1'b0);
        checkOutput("to_after", 8'h02, 3'd1, 1'b1, 1'b0);
`else
        for (int k = 1; k <= 110; k++) begin
            applyStimulus(1'b1, 8'h06, 1'b0);
            checkOutput($sformatf("hold_%0d", k), 8'h04, 3'd2, 1'b1, 1'b0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
